queue_round_robin_n: RTL and testbench

- N-channel transaction sequencer. Each input channel i passes straight through to output channel i.
- Only one channel, the active one, is enabled at a time. Enable rotates between channels at eot-delimited transaction boundaries.
- Generalises the two-channel alternating queue:
  - parametrised channel count;
  - configurable number of transactions per turn;
  - optional skip of idle channels;
  - optional registered outputs.
- Sits between the classifier feature/stage streams and downstream consumers that must see channels interleaved in strict transaction order.

---
 rtl/queue_rr_pkg.sv | 33 +++
 rtl/dti_skid_buffer.sv | 49 ++++
 rtl/queue_round_robin_n.sv | 100 ++++++++++
 tb/tb_queue_round_robin_n.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_rr_pkg.sv
// Shared constants and the round-robin search helper for queue_round_robin_n.
package queue_rr_pkg;

  localparam int MODE_STRICT = 0;
  localparam int MODE_SKIP   = 1;

  // Upper bound on channel count supported by next_valid_ch.
  localparam int unsigned MAX_CH   = 32;
  localparam int unsigned MAX_CH_W = 5;

  // First set bit of valid in order start+1, start+2, ... (mod n); start if none.
  function automatic int unsigned next_valid_ch(
    input logic [MAX_CH-1:0] valid,
    input int unsigned       start,
    input int unsigned       n
  );
    int unsigned idx;
    logic        found;
    next_valid_ch = start;
    found         = 1'b0;
    for (int unsigned k = 1; k < MAX_CH; k++) begin
      if (k < n && !found) begin
        idx = start + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx[MAX_CH_W-1:0]]) begin
          next_valid_ch = idx;
          found         = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/dti_skid_buffer.sv
// Two-entry valid/ready skid buffer; in_ready is simply "not full".
module dti_skid_buffer #(
  parameter int W_DATA = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_DATA-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [W_DATA-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [W_DATA-1:0] head_q;
  logic [W_DATA-1:0] tail_q;
  logic [1:0]        count_q;
  logic              push;
  logic              pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Occupancy and storage update; head always holds the oldest beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= in_data;
          else                 tail_q <= in_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        // Push+pop only possible at one entry: the new beat becomes head.
        2'b11: head_q <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/queue_round_robin_n.sv
// N-channel sequencer: one channel enabled at a time, rotating on eot boundaries.
module queue_round_robin_n
  import queue_rr_pkg::*;
#(
  parameter int N              = 2,
  parameter int W_DATA         = 16,
  parameter int TRANS_PER_TURN = 1,
  parameter int MODE           = MODE_STRICT,
  parameter int OUT_REG        = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N*W_DATA-1:0]                 din_data,
  input  logic [N-1:0]                        din_valid,
  output logic [N-1:0]                        din_ready,
  output logic [N*W_DATA-1:0]                 dout_data,
  output logic [N-1:0]                        dout_valid,
  input  logic [N-1:0]                        dout_ready,
  output logic [$clog2(N)-1:0]                active_ch,
  output logic [$clog2(TRANS_PER_TURN+1)-1:0] txn_cnt
);

  localparam int AW = $clog2(N);
  localparam int CW = $clog2(TRANS_PER_TURN + 1);

  logic [AW-1:0]     active_q;
  logic [CW-1:0]     cnt_q;
  logic              in_txn_q;
  logic [N-1:0]      eot_vec;
  logic [MAX_CH-1:0] valid_ext;
  logic              act_valid;
  logic              act_ready;
  logic              act_eot;
  logic              accept;
  logic              skip_go;
  logic [AW-1:0]     skip_ch;

  assign valid_ext = MAX_CH'(din_valid);
  assign active_ch = active_q;
  assign txn_cnt   = cnt_q;

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic sel;
    assign sel        = (active_q == AW'(g));
    assign eot_vec[g] = din_data[g*W_DATA + W_DATA - 1];

    if (OUT_REG != 0) begin : g_skid
      logic skid_ready;
      dti_skid_buffer #(.W_DATA(W_DATA)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (din_data[g*W_DATA +: W_DATA]),
        .in_valid  (din_valid[g] && sel),
        .in_ready  (skid_ready),
        .out_data  (dout_data[g*W_DATA +: W_DATA]),
        .out_valid (dout_valid[g]),
        .out_ready (dout_ready[g])
      );
      assign din_ready[g] = sel && skid_ready;
    end else begin : g_pass
      assign din_ready[g]                  = sel && dout_ready[g];
      assign dout_valid[g]                 = sel && din_valid[g];
      assign dout_data[g*W_DATA +: W_DATA] = din_data[g*W_DATA +: W_DATA];
    end
  end

  // Active-channel handshake decode and idle-skip decision.
  always_comb begin
    act_valid = din_valid[active_q];
    act_ready = din_ready[active_q];
    act_eot   = eot_vec[active_q];
    accept    = act_valid && act_ready;
    // With the active channel idle, any set valid bit belongs to another channel.
    skip_go   = (MODE == MODE_SKIP) && !in_txn_q && !act_valid && (|din_valid);
    skip_ch   = AW'(next_valid_ch(valid_ext, 32'(active_q), N));
  end

  // Turn state: accepted eot beats count toward rotation; skip only when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= '0;
      cnt_q    <= '0;
      in_txn_q <= 1'b0;
    end else if (accept) begin
      in_txn_q <= !act_eot;
      if (act_eot) begin
        if (cnt_q == CW'(TRANS_PER_TURN - 1)) begin
          cnt_q    <= '0;
          active_q <= (active_q == AW'(N - 1)) ? '0 : active_q + 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end else if (skip_go) begin
      active_q <= skip_ch;
      cnt_q    <= '0;
    end
  end

endmodule

// File: tb/tb_queue_round_robin_n.sv
// Bench for queue_round_robin_n across several parameter sets.
module tb_queue_round_robin_n;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // a: N=2 STRICT TPT=1 pass-through
  logic [2*W-1:0] a_din, a_dout;
  logic [1:0]     a_dv, a_dr, a_ov, a_or;
  logic [0:0]     a_act, a_cnt;
  // b: N=3 STRICT TPT=1
  logic [3*W-1:0] b_din, b_dout;
  logic [2:0]     b_dv, b_dr, b_ov, b_or;
  logic [1:0]     b_act;
  logic [0:0]     b_cnt;
  // c: N=3 STRICT TPT=2
  logic [3*W-1:0] c_din, c_dout;
  logic [2:0]     c_dv, c_dr, c_ov, c_or;
  logic [1:0]     c_act, c_cnt;
  // d: N=4 SKIP TPT=1
  logic [4*W-1:0] d_din, d_dout;
  logic [3:0]     d_dv, d_dr, d_ov, d_or;
  logic [1:0]     d_act;
  logic [0:0]     d_cnt;
  // e: N=2 STRICT TPT=1 registered outputs
  logic [2*W-1:0] e_din, e_dout;
  logic [1:0]     e_dv, e_dr, e_ov, e_or;
  logic [0:0]     e_act, e_cnt;

  queue_round_robin_n #(.N(2), .W_DATA(W), .TRANS_PER_TURN(1), .MODE(0), .OUT_REG(0)) u_a (
    .clk(clk), .rst(rst), .din_data(a_din), .din_valid(a_dv), .din_ready(a_dr),
    .dout_data(a_dout), .dout_valid(a_ov), .dout_ready(a_or), .active_ch(a_act), .txn_cnt(a_cnt));
  queue_round_robin_n #(.N(3), .W_DATA(W), .TRANS_PER_TURN(1), .MODE(0), .OUT_REG(0)) u_b (
    .clk(clk), .rst(rst), .din_data(b_din), .din_valid(b_dv), .din_ready(b_dr),
    .dout_data(b_dout), .dout_valid(b_ov), .dout_ready(b_or), .active_ch(b_act), .txn_cnt(b_cnt));
  queue_round_robin_n #(.N(3), .W_DATA(W), .TRANS_PER_TURN(2), .MODE(0), .OUT_REG(0)) u_c (
    .clk(clk), .rst(rst), .din_data(c_din), .din_valid(c_dv), .din_ready(c_dr),
    .dout_data(c_dout), .dout_valid(c_ov), .dout_ready(c_or), .active_ch(c_act), .txn_cnt(c_cnt));
  queue_round_robin_n #(.N(4), .W_DATA(W), .TRANS_PER_TURN(1), .MODE(1), .OUT_REG(0)) u_d (
    .clk(clk), .rst(rst), .din_data(d_din), .din_valid(d_dv), .din_ready(d_dr),
    .dout_data(d_dout), .dout_valid(d_ov), .dout_ready(d_or), .active_ch(d_act), .txn_cnt(d_cnt));
  queue_round_robin_n #(.N(2), .W_DATA(W), .TRANS_PER_TURN(1), .MODE(0), .OUT_REG(1)) u_e (
    .clk(clk), .rst(rst), .din_data(e_din), .din_valid(e_dv), .din_ready(e_dr),
    .dout_data(e_dout), .dout_valid(e_ov), .dout_ready(e_or), .active_ch(e_act), .txn_cnt(e_cnt));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    a_din = '0; a_dv = '0; a_or = '1;
    b_din = '0; b_dv = '0; b_or = '1;
    c_din = '0; c_dv = '0; c_or = '1;
    d_din = '0; d_dv = '0; d_or = '1;
    e_din = '0; e_dv = '0; e_or = '1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Table for the N=2 STRICT pass-through case; sampled before each edge.
  typedef struct {
    logic [1:0] v;
    logic [1:0] eot;
    logic [1:0] rdy;
    logic       exp_act;
    logic [1:0] exp_dr;
    logic [1:0] exp_ov;
  } vec_t;
  vec_t tbl [11];

  // Reference state for the registered-output instance.
  logic [15:0] e_q [2][$];
  int          e_actm;
  int          e_seq [2];

  // mode: 0 random, 1 drain (no input, full ready), 2 open a transaction.
  task automatic e_cycle(input int mode);
    logic [1:0] exp_ov, exp_dr;
    logic       eot;
    for (int ch = 0; ch < 2; ch++) begin
      e_dv[ch] = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      eot      = (mode == 2) ? 1'b0 : ($urandom_range(0, 2) == 0);
      e_din[ch*W +: W] = {eot, 15'(e_seq[ch])};
      e_seq[ch]++;
    end
    e_or = (mode == 0) ? 2'($urandom) : 2'b11;
    @(negedge clk);
    exp_ov = '0;
    exp_dr = '0;
    for (int ch = 0; ch < 2; ch++) exp_ov[ch] = (e_q[ch].size() != 0);
    exp_dr[e_actm] = (e_q[e_actm].size() < 2);
    check("e_active", 64'(e_act), 64'(e_actm));
    check("e_txn_cnt", 64'(e_cnt), 64'd0);
    check("e_din_ready", 64'(e_dr), 64'(exp_dr));
    check("e_dout_valid", 64'(e_ov), 64'(exp_ov));
    for (int ch = 0; ch < 2; ch++)
      if (exp_ov[ch]) check("e_order", 64'(e_dout[ch*W +: W]), 64'(e_q[ch][0]));
    for (int ch = 0; ch < 2; ch++)
      if (exp_ov[ch] && e_or[ch]) void'(e_q[ch].pop_front());
    if (e_dv[e_actm] && exp_dr[e_actm]) begin
      e_q[e_actm].push_back(e_din[e_actm*W +: W]);
      if (e_din[e_actm*W + W - 1]) e_actm = 1 - e_actm;
    end
    tick();
  endtask

  initial begin
    logic [15:0] exp_word;
    int          d_actm;
    bit          d_open;
    int          bc [3];
    int          t;
    logic [3:0]  v, e, r, oh;

    tbl[0]  = '{2'b11, 2'b10, 2'b11, 1'b0, 2'b01, 2'b01};
    tbl[1]  = '{2'b11, 2'b10, 2'b11, 1'b0, 2'b01, 2'b01};
    tbl[2]  = '{2'b11, 2'b11, 2'b11, 1'b0, 2'b01, 2'b01};
    tbl[3]  = '{2'b11, 2'b10, 2'b11, 1'b1, 2'b10, 2'b10};
    tbl[4]  = '{2'b11, 2'b10, 2'b11, 1'b0, 2'b01, 2'b01};
    tbl[5]  = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 2'b01};
    tbl[6]  = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 2'b01};
    tbl[7]  = '{2'b11, 2'b11, 2'b01, 1'b0, 2'b01, 2'b01};
    tbl[8]  = '{2'b00, 2'b11, 2'b11, 1'b1, 2'b10, 2'b00};
    tbl[9]  = '{2'b10, 2'b10, 2'b11, 1'b1, 2'b10, 2'b10};
    tbl[10] = '{2'b01, 2'b00, 2'b11, 1'b0, 2'b01, 2'b01};

    // Reset state of every instance.
    do_reset();
    @(negedge clk);
    check("rst_a_act", 64'(a_act), 0); check("rst_a_cnt", 64'(a_cnt), 0);
    check("rst_a_dr", 64'(a_dr), 64'b01); check("rst_a_ov", 64'(a_ov), 0);
    check("rst_b_dr", 64'(b_dr), 64'b001); check("rst_b_ov", 64'(b_ov), 0);
    check("rst_c_cnt", 64'(c_cnt), 0); check("rst_d_dr", 64'(d_dr), 64'b0001);
    check("rst_e_act", 64'(e_act), 0); check("rst_e_ov", 64'(e_ov), 0);
    check("rst_e_dr", 64'(e_dr), 64'b01);
    tick();

    // N=2 STRICT table.
    do_reset();
    for (int k = 0; k < 11; k++) begin
      a_dv = tbl[k].v;
      a_or = tbl[k].rdy;
      for (int i = 0; i < 2; i++) a_din[i*W +: W] = {tbl[k].eot[i], 15'(k*4 + i)};
      @(negedge clk);
      check("t1_active", 64'(a_act), 64'(tbl[k].exp_act));
      check("t1_txn_cnt", 64'(a_cnt), 64'd0);
      check("t1_din_ready", 64'(a_dr), 64'(tbl[k].exp_dr));
      check("t1_dout_valid", 64'(a_ov), 64'(tbl[k].exp_ov));
      if (tbl[k].exp_ov != 2'b00) begin
        exp_word = {tbl[k].eot[tbl[k].exp_act], 15'(k*4 + int'(tbl[k].exp_act))};
        check("t1_data", 64'(a_dout[tbl[k].exp_act*W +: W]), 64'(exp_word));
      end
      tick();
    end

    // N=3: eot held with ready low never switches.
    do_reset();
    b_dv = 3'b111;
    for (int i = 0; i < 3; i++) b_din[i*W +: W] = {1'b1, 15'(i)};
    b_or = 3'b000;
    repeat (5) begin
      @(negedge clk);
      check("t2_hold_active", 64'(b_act), 0);
      check("t2_hold_ready", 64'(b_dr), 0);
      tick();
    end
    b_or = 3'b111;
    @(negedge clk);
    check("t2_accept_active", 64'(b_act), 0);
    check("t2_accept_ready", 64'(b_dr), 64'b001);
    tick();
    @(negedge clk);
    check("t2_after_active", 64'(b_act), 1);
    check("t2_after_ready", 64'(b_dr), 64'b010);
    tick();

    // N=3 TPT=2: two 2-beat transactions per turn, wrap 2->0.
    do_reset();
    bc = '{0, 0, 0};
    c_dv = 3'b111;
    c_or = 3'b111;
    for (int cyc = 0; cyc < 15; cyc++) begin
      for (int i = 0; i < 3; i++) c_din[i*W +: W] = {1'(bc[i] % 2), 15'(bc[i])};
      t = cyc / 2;
      @(negedge clk);
      check("t3_active", 64'(c_act), 64'((t / 2) % 3));
      check("t3_txn_cnt", 64'(c_cnt), 64'(t % 2));
      bc[(t / 2) % 3]++;
      tick();
    end

    // N=4 SKIP: only ch2 valid -> bubble, jump to 2; later skip 3 -> 2.
    do_reset();
    d_dv = 4'b0100;
    d_din[2*W +: W] = {1'b0, 15'h22};
    @(negedge clk);
    check("t4_bubble_active", 64'(d_act), 0);
    check("t4_bubble_ready", 64'(d_dr), 64'b0001);
    check("t4_bubble_ov", 64'(d_ov), 0);
    tick();
    @(negedge clk);
    check("t4_skip_active", 64'(d_act), 2);
    check("t4_skip_ready", 64'(d_dr), 64'b0100);
    check("t4_skip_ov", 64'(d_ov), 64'b0100);
    check("t4_skip_data", 64'(d_dout[2*W +: W]), 64'h0022);
    tick();
    d_din[2*W +: W] = {1'b1, 15'h23};
    @(negedge clk);
    check("t4_eot_active", 64'(d_act), 2);
    tick();
    @(negedge clk);
    check("t4_rot_active", 64'(d_act), 3);
    check("t4_rot_ov", 64'(d_ov), 0);
    tick();
    @(negedge clk);
    check("t4_wrap_skip_active", 64'(d_act), 2);
    check("t4_wrap_skip_ov", 64'(d_ov), 64'b0100);
    tick();

    // SKIP never leaves an open transaction.
    do_reset();
    d_dv = 4'b0011;
    d_din[0 +: W] = {1'b0, 15'h10};
    d_din[W +: W] = {1'b1, 15'h11};
    @(negedge clk);
    check("t5_open_active", 64'(d_act), 0);
    tick();
    d_dv = 4'b0010;
    repeat (3) begin
      @(negedge clk);
      check("t5_hold_active", 64'(d_act), 0);
      check("t5_hold_ov", 64'(d_ov), 0);
      tick();
    end
    d_dv = 4'b0011;
    d_din[0 +: W] = {1'b1, 15'h12};
    @(negedge clk);
    check("t5_eot_active", 64'(d_act), 0);
    tick();
    d_dv = 4'b0010;
    @(negedge clk);
    check("t5_after_active", 64'(d_act), 1);
    check("t5_after_ov", 64'(d_ov), 64'b0010);
    tick();

    // N=4 SKIP random against the turn-ownership model.
    do_reset();
    d_actm = 0;
    d_open = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      v = 4'($urandom) & 4'($urandom);
      e = 4'($urandom);
      r = 4'($urandom) | 4'($urandom);
      d_dv = v;
      d_or = r;
      for (int i = 0; i < 4; i++) d_din[i*W +: W] = {e[i], 15'(cyc*4 + i)};
      oh = 4'(1) << d_actm;
      @(negedge clk);
      check("rd_active", 64'(d_act), 64'(d_actm));
      check("rd_txn_cnt", 64'(d_cnt), 64'd0);
      check("rd_din_ready", 64'(d_dr), 64'(r[d_actm] ? oh : 4'b0000));
      check("rd_dout_valid", 64'(d_ov), 64'(v[d_actm] ? oh : 4'b0000));
      if (v[d_actm]) check("rd_data", 64'(d_dout[d_actm*W +: W]), 64'({e[d_actm], 15'(cyc*4 + d_actm)}));
      if (v[d_actm] && r[d_actm]) begin
        d_open = !e[d_actm];
        if (e[d_actm]) d_actm = (d_actm + 1) % 4;
      end else if (!d_open && !v[d_actm] && v != 4'b0000) begin
        int k;
        k = 1;
        while (!v[(d_actm + k) % 4]) k++;
        d_actm = (d_actm + k) % 4;
      end
      tick();
    end

    // Registered outputs: random backpressure, drain, mid-transaction reset.
    do_reset();
    e_actm = 0;
    e_seq = '{0, 1000};
    repeat (200) e_cycle(0);
    repeat (4) e_cycle(1);
    check("e_drain1_ch0", 64'(e_q[0].size()), 0);
    check("e_drain1_ch1", 64'(e_q[1].size()), 0);
    e_cycle(2);
    rst = 1'b1;
    e_dv = '0;
    tick();
    rst = 1'b0;
    e_q[0].delete();
    e_q[1].delete();
    e_actm = 0;
    @(negedge clk);
    check("e_postrst_ov", 64'(e_ov), 0);
    check("e_postrst_act", 64'(e_act), 0);
    check("e_postrst_cnt", 64'(e_cnt), 0);
    tick();
    repeat (200) e_cycle(0);
    repeat (4) e_cycle(1);
    check("e_drain2_ch0", 64'(e_q[0].size()), 0);
    check("e_drain2_ch1", 64'(e_q[1].size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
